// File: rtl/axi_m0_pkg.sv
// Shared types and constants for the M0 AXI burst master: FSM state encoding,
// fixed AXI field values, response codes and M0 port widths.
package axi_m0_pkg;

    // M0 port widths
    localparam int unsigned M0_ADDR_W  = 32;
    localparam int unsigned M0_LEN_W   = 3;
    localparam int unsigned M0_ID_W    = 4;
    localparam int unsigned M0_DATA_W  = 64;
    localparam int unsigned M0_STRB_W  = 8;

    // Fixed request-channel field values
    localparam logic [2:0] AXI_SIZE_64    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_MOD  = 4'b0011;
    localparam logic [2:0] AXI_PROT_NONE  = 3'b000;

    // Response codes; numeric order doubles as severity order
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWrAddr,
        StWrData,
        StWrResp,
        StDone
    } m0_state_e;

    // Worse of two responses (higher code is more severe)
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_m0_beat_ctr.sv
// Beat counter: latches the burst length on load, counts data handshakes and
// flags the final beat of the burst.
module axi_m0_beat_ctr
    import axi_m0_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [M0_LEN_W-1:0] load_len,
    input  logic                step,
    output logic [M0_LEN_W-1:0] count,
    output logic [M0_LEN_W-1:0] beat_len,
    output logic                last
);

    logic [M0_LEN_W-1:0] count_q, count_d;
    logic [M0_LEN_W-1:0] len_q, len_d;

    // Next count/length: load restarts the burst, step advances one beat
    always_comb begin
        count_d = count_q;
        len_d   = len_q;
        if (load) begin
            count_d = '0;
            len_d   = load_len;
        end else if (step) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter and length registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            len_q   <= '0;
        end else begin
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    assign count    = count_q;
    assign beat_len = len_q;
    assign last     = (count_q == len_q);

endmodule

// File: rtl/axi_m0_burst_master.sv
// Single-outstanding AXI burst master on the M0 port. Accepts one read or
// write command, issues the address, streams data between the user ports and
// the bus, and reports completion with worst response and an error flag.
// Optional watchdog: define AXI_M0_MASTER_TIMEOUT_EN.
module axi_m0_burst_master
    import axi_m0_pkg::*;
#(
    parameter logic [M0_ID_W-1:0] AXI_ID         = 4'h0,
    parameter int unsigned        TIMEOUT_CYCLES = 1024
) (
    input  logic                  M0_ACLK,
    input  logic                  M0_ARESETN,
    // command
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [M0_ADDR_W-1:0]  cmd_addr,
    input  logic [M0_LEN_W-1:0]   cmd_len,
    // write data stream
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [M0_DATA_W-1:0]  wr_data,
    input  logic [M0_STRB_W-1:0]  wr_strb,
    // read data stream
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [M0_DATA_W-1:0]  rd_data,
    output logic                  rd_last,
    // completion
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  done_err,
    // AR channel
    output logic [M0_ADDR_W-1:0]  M0_ARADDR,
    output logic [M0_LEN_W-1:0]   M0_ARLEN,
    output logic [M0_ID_W-1:0]    M0_ARID,
    output logic [2:0]            M0_ARSIZE,
    output logic [1:0]            M0_ARBURST,
    output logic [3:0]            M0_ARCACHE,
    output logic [2:0]            M0_ARPROT,
    output logic                  M0_ARLOCK,
    output logic                  M0_ARVALID,
    input  logic                  M0_ARREADY,
    // AW channel
    output logic [M0_ADDR_W-1:0]  M0_AWADDR,
    output logic [M0_LEN_W-1:0]   M0_AWLEN,
    output logic [M0_ID_W-1:0]    M0_AWID,
    output logic [2:0]            M0_AWSIZE,
    output logic [1:0]            M0_AWBURST,
    output logic [3:0]            M0_AWCACHE,
    output logic [2:0]            M0_AWPROT,
    output logic                  M0_AWLOCK,
    output logic                  M0_AWVALID,
    input  logic                  M0_AWREADY,
    // W channel
    output logic [M0_DATA_W-1:0]  M0_WDATA,
    output logic [M0_STRB_W-1:0]  M0_WSTRB,
    output logic                  M0_WLAST,
    output logic                  M0_WVALID,
    input  logic                  M0_WREADY,
    // R channel
    input  logic [M0_DATA_W-1:0]  M0_RDATA,
    input  logic [M0_ID_W-1:0]    M0_RID,
    input  logic [1:0]            M0_RRESP,
    input  logic                  M0_RLAST,
    input  logic                  M0_RVALID,
    output logic                  M0_RREADY,
    // B channel
    input  logic [M0_ID_W-1:0]    M0_BID,
    input  logic [1:0]            M0_BRESP,
    input  logic                  M0_BVALID,
    output logic                  M0_BREADY
);

    m0_state_e state_q, state_d;
    logic [M0_ADDR_W-4:0] addr_q;
    logic [1:0]           resp_q, resp_d;
    logic                 err_q, err_d;

    logic                 cmd_fire, ar_fire, aw_fire, w_fire, r_fire, b_fire;
    logic                 beat_last;
    logic [M0_LEN_W-1:0]  beat_cnt;
    logic [M0_LEN_W-1:0]  beat_len;
    logic                 timeout;

    // Handshake qualifiers, each gated by the owning state
    assign cmd_ready = (state_q == StIdle) && M0_ARESETN;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign ar_fire   = M0_ARVALID && M0_ARREADY;
    assign aw_fire   = M0_AWVALID && M0_AWREADY;
    assign w_fire    = M0_WVALID && M0_WREADY;
    assign r_fire    = M0_RVALID && M0_RREADY;
    assign b_fire    = M0_BVALID && M0_BREADY;

    axi_m0_beat_ctr u_beat_ctr (
        .clk      (M0_ACLK),
        .rst_n    (M0_ARESETN),
        .load     (cmd_fire),
        .load_len (cmd_len),
        .step     (r_fire || w_fire),
        .count    (beat_cnt),
        .beat_len (beat_len),
        .last     (beat_last)
    );

`ifdef AXI_M0_MASTER_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
    logic [ToW-1:0] to_q, to_d;
    logic           waiting;
    logic           any_fire;

    assign any_fire = ar_fire || aw_fire || w_fire || r_fire || b_fire;
    assign waiting  = (state_q != StIdle) && (state_q != StDone) && !any_fire;
    assign timeout  = waiting && (to_q == ToW'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts stalled cycles, any bus handshake restarts it
    always_comb begin
        to_d = '0;
        if (waiting) begin
            to_d = to_q + 1'b1;
        end
    end

    // Watchdog register
    always_ff @(posedge M0_ACLK or negedge M0_ARESETN) begin
        if (!M0_ARESETN) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state, response accumulation and sticky error
    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    state_d = cmd_write ? StWrAddr : StRdAddr;
                    resp_d  = AXI_RESP_OKAY;
                    err_d   = 1'b0;
                end
            end
            StRdAddr: begin
                if (ar_fire) state_d = StRdData;
            end
            StRdData: begin
                if (r_fire) begin
                    resp_d = worst_resp(resp_q, M0_RRESP);
                    // early or missing RLAST, or foreign ID
                    if ((M0_RLAST != beat_last) || (M0_RID != AXI_ID)) err_d = 1'b1;
                    if (M0_RLAST || beat_last) state_d = StDone;
                end
            end
            StWrAddr: begin
                if (aw_fire) state_d = StWrData;
            end
            StWrData: begin
                if (w_fire && beat_last) state_d = StWrResp;
            end
            StWrResp: begin
                if (b_fire) begin
                    resp_d  = M0_BRESP;
                    if (M0_BID != AXI_ID) err_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (timeout) begin
            state_d = StDone;
            resp_d  = AXI_RESP_SLVERR;
            err_d   = 1'b1;
        end
    end

    // State, latched address and completion status registers
    always_ff @(posedge M0_ACLK or negedge M0_ARESETN) begin
        if (!M0_ARESETN) begin
            state_q <= StIdle;
            addr_q  <= '0;
            resp_q  <= AXI_RESP_OKAY;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            if (cmd_fire) addr_q <= cmd_addr[M0_ADDR_W-1:3];
        end
    end

    // Request channels: fixed fields, 8-byte aligned address
    assign M0_ARADDR  = {addr_q, 3'b000};
    assign M0_ARLEN   = beat_len;
    assign M0_ARID    = AXI_ID;
    assign M0_ARSIZE  = AXI_SIZE_64;
    assign M0_ARBURST = AXI_BURST_INCR;
    assign M0_ARCACHE = AXI_CACHE_MOD;
    assign M0_ARPROT  = AXI_PROT_NONE;
    assign M0_ARLOCK  = 1'b0;
    assign M0_ARVALID = (state_q == StRdAddr);

    assign M0_AWADDR  = {addr_q, 3'b000};
    assign M0_AWLEN   = beat_len;
    assign M0_AWID    = AXI_ID;
    assign M0_AWSIZE  = AXI_SIZE_64;
    assign M0_AWBURST = AXI_BURST_INCR;
    assign M0_AWCACHE = AXI_CACHE_MOD;
    assign M0_AWPROT  = AXI_PROT_NONE;
    assign M0_AWLOCK  = 1'b0;
    assign M0_AWVALID = (state_q == StWrAddr);

    // Write stream passes straight through while in the data phase
    assign M0_WDATA  = wr_data;
    assign M0_WSTRB  = wr_strb;
    assign M0_WVALID = (state_q == StWrData) && wr_valid;
    assign M0_WLAST  = (state_q == StWrData) && beat_last;
    assign wr_ready  = (state_q == StWrData) && M0_WREADY;

    // Read stream passes straight through while in the data phase
    assign rd_data   = M0_RDATA;
    assign rd_valid  = (state_q == StRdData) && M0_RVALID;
    assign rd_last   = (state_q == StRdData) && M0_RLAST;
    assign M0_RREADY = (state_q == StRdData) && rd_ready;

    assign M0_BREADY = (state_q == StWrResp);

    // Completion status is only presented during the done pulse
    assign done      = (state_q == StDone);
    assign done_resp = done ? resp_q : AXI_RESP_OKAY;
    assign done_err  = done && err_q;

endmodule

// File: tb/tb_axi_m0_burst_master.sv
// Directed bench for axi_m0_burst_master. Timeout scenario runs only when
// AXI_M0_MASTER_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=16).
module tb_axi_m0_burst_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [2:0]  cmd_len = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [63:0] wr_data = '0;
    logic [7:0]  wr_strb = '0;
    logic        rd_valid, rd_ready = 1'b0, rd_last;
    logic [63:0] rd_data;
    logic        done, done_err;
    logic [1:0]  done_resp;
    logic [31:0] araddr, awaddr;
    logic [2:0]  arlen, awlen, arsize, awsize, arprot, awprot;
    logic [3:0]  arid, awid, arcache, awcache;
    logic [1:0]  arburst, awburst;
    logic        arlock, awlock, arvalid, awvalid;
    logic        arready = 1'b0, awready = 1'b0, wready = 1'b0;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid;
    logic [63:0] rdata = '0;
    logic [3:0]  rid = '0, bid = '0;
    logic [1:0]  rresp = '0, bresp = '0;
    logic        rlast = 1'b0, rvalid = 1'b0, rready;
    logic        bvalid = 1'b0, bready;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_m0_burst_master #(
        .AXI_ID         (4'h0),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .M0_ACLK    (clk),     .M0_ARESETN (rst_n),
        .cmd_valid  (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
        .cmd_addr   (cmd_addr),  .cmd_len   (cmd_len),
        .wr_valid   (wr_valid),  .wr_ready  (wr_ready),  .wr_data (wr_data),
        .wr_strb    (wr_strb),
        .rd_valid   (rd_valid),  .rd_ready  (rd_ready),  .rd_data (rd_data),
        .rd_last    (rd_last),
        .done       (done),      .done_resp (done_resp), .done_err (done_err),
        .M0_ARADDR  (araddr),  .M0_ARLEN  (arlen),   .M0_ARID    (arid),
        .M0_ARSIZE  (arsize),  .M0_ARBURST (arburst), .M0_ARCACHE (arcache),
        .M0_ARPROT  (arprot),  .M0_ARLOCK (arlock),  .M0_ARVALID (arvalid),
        .M0_ARREADY (arready),
        .M0_AWADDR  (awaddr),  .M0_AWLEN  (awlen),   .M0_AWID    (awid),
        .M0_AWSIZE  (awsize),  .M0_AWBURST (awburst), .M0_AWCACHE (awcache),
        .M0_AWPROT  (awprot),  .M0_AWLOCK (awlock),  .M0_AWVALID (awvalid),
        .M0_AWREADY (awready),
        .M0_WDATA   (wdata),   .M0_WSTRB  (wstrb),   .M0_WLAST   (wlast),
        .M0_WVALID  (wvalid),  .M0_WREADY (wready),
        .M0_RDATA   (rdata),   .M0_RID    (rid),     .M0_RRESP   (rresp),
        .M0_RLAST   (rlast),   .M0_RVALID (rvalid),  .M0_RREADY  (rready),
        .M0_BID     (bid),     .M0_BRESP  (bresp),   .M0_BVALID  (bvalid),
        .M0_BREADY  (bready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] l);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        #1;
        check("cmd_ready_idle", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    int k;
    int n;
    logic [63:0] exp_data;

    initial begin
        // reset state
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_done", done, 0);
        check("rst_done_resp", done_resp, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // read len=3 at 0x1000, rd_ready always 1
        issue(1'b0, 32'h0000_1000, 3'd3);
        #1;
        check("rd1_arvalid", arvalid, 1);
        check("rd1_araddr", araddr, 64'h1000);
        check("rd1_arlen", arlen, 3);
        check("rd1_arfixed", {arsize, arburst, arcache, arprot, arlock, arid},
              {3'b011, 2'b01, 4'b0011, 3'b000, 1'b0, 4'h0});
        check("rd1_cmd_ready_busy", cmd_ready, 0);
        step();
        check("rd1_arvalid_held", arvalid, 1);
        arready = 1'b1;
        step();
        arready = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rvalid = 1'b1; rdata = 64'h1111_0000_0000_0000 + 64'(i); rlast = (i == 3);
            rresp = 2'b00;
            #1;
            check("rd1_rd_valid", rd_valid, 1);
            check("rd1_rd_data", rd_data, 64'h1111_0000_0000_0000 + 64'(i));
            check("rd1_rd_last", rd_last, (i == 3));
            check("rd1_rready", rready, 1);
            step();
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        check("rd1_done", done, 1);
        check("rd1_done_resp", done_resp, 0);
        check("rd1_done_err", done_err, 0);
        step();
        check("rd1_done_one_cycle", done, 0);
        check("rd1_back_idle", cmd_ready, 1);

        // write len=0 at 0x2004, strobe 0xF0, BRESP=SLVERR
        issue(1'b1, 32'h0000_2004, 3'd0);
        #1;
        check("wr1_awvalid", awvalid, 1);
        check("wr1_awaddr", awaddr, 64'h2000);
        check("wr1_awlen", awlen, 0);
        awready = 1'b1;
        step();
        awready = 1'b0;
        wr_valid = 1'b1; wr_data = 64'hDEAD_BEEF_0123_4567; wr_strb = 8'hF0;
        #1;
        check("wr1_wvalid", wvalid, 1);
        check("wr1_wlast", wlast, 1);
        check("wr1_wstrb", wstrb, 8'hF0);
        check("wr1_wdata", wdata, 64'hDEAD_BEEF_0123_4567);
        check("wr1_wr_ready_low", wr_ready, 0);
        wready = 1'b1;
        #1;
        check("wr1_wr_ready", wr_ready, 1);
        step();
        wready = 1'b0; wr_valid = 1'b0;
        #1;
        check("wr1_bready", bready, 1);
        check("wr1_wvalid_off", wvalid, 0);
        bvalid = 1'b1; bresp = 2'b10;
        step();
        bvalid = 1'b0; bresp = 2'b00;
        #1;
        check("wr1_done", done, 1);
        check("wr1_done_resp", done_resp, 2'b10);
        check("wr1_done_err", done_err, 0);
        step();

        // read len=7, rd_ready toggling every cycle
        issue(1'b0, 32'h0000_3000, 3'd7);
        arready = 1'b1;
        step();
        arready = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
            rvalid = 1'b1; rlast = (k == 7);
            rdata = 64'hA5A5_0000_0000_0000 + 64'(k);
            rd_ready = cyc[0];
            #1;
            if (rd_ready) begin
                exp_data = 64'hA5A5_0000_0000_0000 + 64'(k);
                check("rd8_rd_data", rd_data, exp_data);
                check("rd8_rready_on", rready, 1);
                k++;
            end else begin
                check("rd8_rready_off", rready, 0);
            end
            step();
        end
        rvalid = 1'b0; rlast = 1'b0; rd_ready = 1'b1;
        #1;
        check("rd8_done", done, 1);
        check("rd8_done_err", done_err, 0);
        step();

        // read len=3 with early RLAST on the third beat; one beat EXOKAY
        issue(1'b0, 32'h0000_4000, 3'd3);
        arready = 1'b1;
        step();
        arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rvalid = 1'b1; rlast = (i == 2); rresp = (i == 1) ? 2'b01 : 2'b00;
            rdata = 64'(i);
            step();
            #1;
            check("early_done_timing", done, (i == 2));
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        check("early_done_err", done_err, 1);
        check("early_done_resp", done_resp, 2'b01);
        step();

        // read len=0 with wrong RID
        issue(1'b0, 32'h0000_5000, 3'd0);
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rlast = 1'b1; rid = 4'h5;
        step();
        rvalid = 1'b0; rlast = 1'b0; rid = 4'h0;
        #1;
        check("rid_done", done, 1);
        check("rid_done_err", done_err, 1);
        step();

        // write with AWREADY withheld, reset pulsed mid-wait
        issue(1'b1, 32'h0000_6000, 3'd1);
        step();
        step();
        check("rstmid_awvalid_wait", awvalid, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_awvalid", awvalid, 0);
        check("rstmid_cmd_ready", cmd_ready, 0);
        check("rstmid_other", {arvalid, wvalid, wlast, bready, rready, wr_ready, rd_valid, done,
                               done_err, done_resp}, 0);
        step();
        check("rstmid_held", {awvalid, cmd_ready, done}, 0);
        rst_n = 1'b1;
        step();
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || awvalid) n++;
            step();
        end
        check("rstmid_no_done", n, 0);
        check("rstmid_idle", cmd_ready, 1);

`ifdef AXI_M0_MASTER_TIMEOUT_EN
        // BVALID never arrives: watchdog forces done after 16 stalled cycles
        issue(1'b1, 32'h0000_7000, 3'd0);
        awready = 1'b1;
        step();
        awready = 1'b0;
        wr_valid = 1'b1; wready = 1'b1;
        step();
        wr_valid = 1'b0; wready = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            n++;
            if (done) break;
        end
        check("to_cycles", n, 16);
        check("to_done", done, 1);
        check("to_done_err", done_err, 1);
        check("to_done_resp", done_resp, 2'b10);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_m0_burst_master.md
AXI_M0_BURST_MASTER -- requirements
Module: axi_m0_burst_master

Interface
REQ-001 Parameter AXI_ID, default 4'h0, ID driven on M0_ARID/M0_AWID and expected on M0_RID/M0_BID.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, watchdog limit in cycles (used only with the Configuration macro).
REQ-003 M0_ACLK  in  1  sole clock; all logic rising-edge.
REQ-004 M0_ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-006 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-007 cmd_addr  in  32  byte address; bits [2:0] forced to 0 on the bus.
REQ-008 cmd_len  in  3  beats minus one (1..8 beats).
REQ-009 wr_valid/wr_ready  in/out  1/1  write-data stream handshake.
REQ-010 wr_data, wr_strb  in  64, 8  write beat payload and byte strobes.
REQ-011 rd_valid/rd_ready  out/in  1/1  read-data stream handshake.
REQ-012 rd_data, rd_last  out  64, 1  read beat payload; rd_last marks final beat.
REQ-013 done, done_resp, done_err  out  1, 2, 1  one-cycle completion pulse, worst AXI response, protocol/timeout error.
REQ-014 M0_AR*, M0_AW*, M0_W*  out  per M0 port widths (ADDR 32, LEN 3, ID 4, SIZE 3, BURST 2, CACHE 4, PROT 3, LOCK 1, DATA 64, STRB 8, LAST 1, VALID 1)  request channels; M0_ARREADY/AWREADY/WREADY in.
REQ-015 M0_R*, M0_B*  in  (DATA 64, ID 4, RESP 2, LAST 1, VALID 1)  response channels; M0_RREADY/M0_BREADY out.

Function
REQ-016 FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE; one transaction outstanding at a time.
REQ-017 cmd_ready=1 only in IDLE; cmd handshake latches addr/len/write and moves to RD_ADDR or WR_ADDR next cycle.
REQ-018 Fixed fields: SIZE=3'b011, BURST=2'b01 (INCR), CACHE=4'b0011, PROT=3'b000, LOCK=0, ID=AXI_ID.
REQ-019 ARVALID/AWVALID asserted in RD_ADDR/WR_ADDR, held stable until READY; handshake advances to RD_DATA/WR_DATA.
REQ-020 WR_DATA: M0_WVALID=wr_valid, wr_ready=M0_WREADY, data/strb pass through combinationally; beat counter drives M0_WLAST on beat cmd_len.
REQ-021 After last W handshake go to WR_RESP; M0_BREADY=1 only there; B handshake goes to DONE.
REQ-022 RD_DATA: rd_valid=M0_RVALID, M0_RREADY=rd_ready, rd_data=M0_RDATA, rd_last=M0_RLAST; backpressure honoured with zero added latency.
REQ-023 RLAST on beat before cmd_len, missing RLAST on beat cmd_len, or RID/BID != AXI_ID sets sticky done_err for the transaction; RLAST or beat cmd_len ends RD_DATA.
REQ-024 done_resp = max RRESP over all beats (reads) or BRESP (writes).
REQ-025 DONE lasts exactly one cycle with done=1, then IDLE; next cmd accepted earliest the cycle after.
REQ-026 Bursts crossing a 4 KB boundary are not split; caller responsibility; done_err not set for them.

Reset
REQ-027 M0_ARESETN low: FSM to IDLE, beat counter 0, all VALID/READY/LAST/done/done_err outputs 0, done_resp 2'b00, cmd_ready 0 while low.
REQ-028 Reset mid-burst abandons the transaction with no done pulse; bus outputs 0 immediately (asynchronous).

Configuration
REQ-029 Macro AXI_M0_MASTER_TIMEOUT_EN defined: counter runs in every non-IDLE state, clears on any M0 handshake; reaching TIMEOUT_CYCLES forces DONE with done_err=1, done_resp=2'b10.
REQ-030 Macro undefined: no counter logic; FSM waits indefinitely.

Structure
REQ-031 Package axi_m0_pkg holds FSM state enum, AXI_SIZE_64, AXI_BURST_INCR, AXI_RESP_* constants and M0 width localparams.
REQ-032 One sub-module axi_m0_beat_ctr (load len, count handshakes, flag last); no other hierarchy.

Verification
REQ-033 Read len=3 at 0x1000, slave RRESP OKAY, rd_ready always 1 -> ARADDR=0x1000, ARLEN=3, 4 beats out, rd_last on 4th, done pulse, done_resp=00.
REQ-034 Write len=0 at 0x2004, wr_strb=0xF0 -> AWADDR=0x2000, single beat WLAST=1, WSTRB=0xF0, BRESP=SLVERR gives done_resp=10.
REQ-035 Read len=7 with rd_ready toggled every cycle -> each RDATA beat seen exactly once, no data loss, 8 beats.
REQ-036 Read len=3, slave asserts RLAST on beat 2 -> done after beat 2 with done_err=1.
REQ-037 Write with slave AWREADY withheld, reset pulsed mid-wait -> all outputs 0 during reset, IDLE after, no done.
REQ-038 With AXI_M0_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, BVALID never asserted -> done at 16 idle cycles, done_err=1, done_resp=10.
